// File: rtl/ula_pkg.sv
// Shared opcodes, flag bit positions and FSM encodings for the ULA execute sequencer.
package ula_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_MUL = 5'b00101;
  localparam logic [4:0] OP_DIV = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00111;

  localparam int FLG_EQ  = 0;
  localparam int FLG_ABV = 1;
  localparam int FLG_BLW = 2;
  localparam int FLG_OVF = 3;
  localparam int FLG_ERR = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_op_latency.sv
// Maps {opcode, b_is_zero} to the EXEC counter load value (cycles allotted minus one).
module ula_op_latency
  import ula_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CW         = 4
) (
  input  logic [4:0]    opcode,
  input  logic          b_is_zero,
  output logic [CW-1:0] load
);

  always_comb begin
    load = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND: load = '0;
      OP_MUL:                 load = CW'(MUL_CYCLES - 1);
      // a zero divisor is resolved by the controller, so no need to wait for the ULA
      OP_DIV:                 load = b_is_zero ? '0 : CW'(DIV_CYCLES - 1);
      default:                load = '0;
    endcase
  end

endmodule

// File: rtl/ula_ctrl.sv
// Execute-stage sequencer: latches one request, holds the ULA inputs for the op's budget,
// captures result/flags into a response register and keeps a sticky overflow bit.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_inst,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] ula_operand_a,
  output logic [WIDTH-1:0] ula_operand_b,
  output logic [31:0]      ula_inst,
  input  logic [WIDTH-1:0] ula_result,
  input  logic             ula_equal,
  input  logic             ula_above,
  input  logic             ula_below,
  input  logic             ula_overflow,
  input  logic             ula_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_flags,
  output logic             busy,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_load;
  logic             div_zero;
  logic             b_is_zero;
  logic             accept;
  logic             capture;
  logic [WIDTH-1:0] cap_result;
  logic [4:0]       cap_flags;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign b_is_zero = (req_b == '0);
  assign accept    = req_valid && req_ready;
  assign capture   = (state == S_EXEC) && (cnt == '0);

  ula_op_latency #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CW         (CW)
  ) u_lat (
    .opcode    (req_inst[31:27]),
    .b_is_zero (b_is_zero),
    .load      (cnt_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // divide-by-zero overrides whatever the ULA drives
  always_comb begin
    cap_result = ula_result;
    cap_flags  = {ula_error, ula_overflow, ula_below, ula_above, ula_equal};
    if (div_zero) begin
      cap_result         = '0;
      cap_flags[FLG_ERR] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      div_zero      <= 1'b0;
      ula_operand_a <= '0;
      ula_operand_b <= '0;
      ula_inst      <= '0;
    end else if (accept) begin
      cnt           <= cnt_load;
      div_zero      <= (req_inst[31:27] == OP_DIV) && b_is_zero;
      ula_operand_a <= req_a;
      ula_operand_b <= req_b;
      ula_inst      <= req_inst;
    end else if (state == S_EXEC && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (capture) begin
      rsp_result <= cap_result;
      rsp_flags  <= cap_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  sticky_ovf <= 1'b0;
    else if (capture && cap_flags[FLG_OVF])   sticky_ovf <= 1'b1;
    else if (clr_sticky)                      sticky_ovf <= 1'b0;
  end

endmodule
